channel_arbiter: RTL and testbench
==================================

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 16, number of requesters; equals mux channel count, fixed at 16.
REQ-002 SHALL have parameter MAX_HOLD, default 64, max cycles one owner holds the mux; used only when ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  16  per-requester request; bit i requests mux channel i.
REQ-006 SHALL have port done  input  1  current owner releases the mux this cycle.
REQ-007 SHALL have port select  output  16  one-hot channel select driving the 16-channel mux select input.
REQ-008 SHALL have port valid  output  1  high while any select bit is high.
REQ-009 SHALL have port owner  output  4  binary index of the granted channel; 0 when valid=0.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 SHALL implement FSM states IDLE and GRANT; all outputs registered.
REQ-012 SHALL, in IDLE with req!=0, grant the first set req bit scanning upward from pointer ptr with wrap 15->0, entering GRANT next edge.
REQ-013 SHALL have one-cycle grant latency: req seen at edge N gives select/valid/owner valid after edge N.
REQ-014 SHALL, on each grant, set ptr = winner+1 mod 16 (winner 15 -> ptr 0).
REQ-015 SHALL, in GRANT, hold select constant until release: done=1, or req[owner]=0.
REQ-016 SHALL, on release, return to IDLE with select=0 for exactly one cycle before any new grant (no select overlap/glitch at mux).
REQ-017 SHALL ignore done while in IDLE.
REQ-018 SHALL treat done plus other requests in the same cycle as release; the next grant follows the REQ-016 bubble using the updated ptr.
REQ-019 SHALL ensure select is always one-hot or all-zero; select[owner]=1 whenever valid=1.
REQ-020 SHALL deny a request that was raised during another owner's grant until that owner releases; no preemption.

Reset
REQ-021 SHALL, on rst_n low, immediately force state=IDLE, select=0, valid=0, owner=0, timeout=0, ptr=0, hold counter=0, regardless of clock.
REQ-022 SHALL, on rst_n asserted mid-GRANT, drop select combinationally from the flops (no completion of the transfer).
REQ-023 SHALL, after rst_n deasserts, evaluate req at the first rising edge with ptr=0.

Configuration
REQ-024 SHALL, with ARB_TIMEOUT_EN defined, count GRANT cycles; when the count reaches MAX_HOLD without release, force release (as REQ-016) and pulse timeout for one cycle.
REQ-025 SHALL reload the hold counter to 0 on every new grant.
REQ-026 SHALL, without ARB_TIMEOUT_EN, omit the counter, allow unbounded holds, and tie timeout to 0; the port list is unchanged.

Structure
REQ-027 SHALL place NREQ, owner width (4), and the FSM state enum typedef in shared package arb_pkg.
REQ-028 SHALL implement the rotating priority pick (req, ptr -> one-hot winner, index) as sub-module rr_pick, purely combinational.
REQ-029 SHALL leave the mux itself outside this block; select connects directly to the mux select input.

Verification
REQ-030 SHALL test: after reset, req=16'h0001 -> after 1 edge select=16'h0001, owner=0, valid=1; done=1 -> select=0 next edge.
REQ-031 SHALL test: req=16'hFFFF held, done pulsed at each grant -> owners 0,1,2,...,15,0 in order, with one zero-select cycle between each.
REQ-032 SHALL test: ptr=15 (after owner 14), req=16'h0003 -> owner=0 (wrap), not 1.
REQ-033 SHALL test: owner 5 granted, req[5] drops without done -> release; select=0 one cycle; then req[9] set -> owner=9.
REQ-034 SHALL test: ARB_TIMEOUT_EN, MAX_HOLD=4, req=16'h0010, no done -> timeout=1 once after 4 GRANT cycles, select=0 next cycle, then re-grant to 4.
REQ-035 SHALL test: rst_n low mid-GRANT between clock edges -> select=0 and valid=0 immediately; ptr=0 after release.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared sizes and FSM state type for channel_arbiter
package arb_pkg;
  localparam int NREQ = 16;
  localparam int OW   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority pick: first set req bit at or above ptr, wrapping
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [OW-1:0]   idx,
  output logic            any
);

  logic [OW-1:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = '0;
    // 4-bit add wraps naturally, giving the 15 -> 0 scan order
    for (int i = 0; i < NREQ; i++) begin
      k = ptr + OW'(i);
      if (!any && req[k]) begin
        any       = 1'b1;
        idx       = k;
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_arbiter.sv
// rtl/channel_arbiter.sv - round-robin owner arbiter driving a one-hot mux select
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module channel_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ     = arb_pkg::NREQ,
  parameter int MAX_HOLD = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] select,
  output logic            valid,
  output logic [OW-1:0]   owner,
  output logic            timeout
);

  state_t        state;
  logic [OW-1:0] ptr;
  logic [NREQ-1:0] pick_onehot;
  logic [OW-1:0] pick_idx;
  logic          pick_any;
  logic          user_rel;
  logic          forced;
  logic          release_now;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign user_rel    = done || !req[owner];
  assign release_now = user_rel || forced;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Counter is zero in the first GRANT cycle because every grant is preceded by IDLE
  assign forced = (state == GRANT) && !user_rel && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
      timeout  <= forced;
    end
  end
`else
  logic unused_hold;

  assign unused_hold = (MAX_HOLD > 0);
  assign forced      = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      select <= '0;
      valid  <= 1'b0;
      owner  <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state  <= GRANT;
            select <= pick_onehot;
            valid  <= 1'b1;
            owner  <= pick_idx;
            ptr    <= pick_idx + 1'b1;
          end
        end
        GRANT: begin
          // Always pass through IDLE so the mux sees an all-zero select between owners
          if (release_now) begin
            state  <= IDLE;
            select <= '0;
            valid  <= 1'b0;
            owner  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_arbiter.sv
// tb/tb_channel_arbiter.sv - self-checking bench for channel_arbiter (directed table + randomized model)
module tb_channel_arbiter;

  localparam int TB_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] select;
  logic        valid;
  logic [3:0]  owner;
  logic        timeout;

  int n_total;
  int n_pass;

  int m_valid;
  int m_owner;
  int m_ptr;
  int m_hold;
  int m_to;

  typedef struct {
    logic [15:0] r;
    logic        d;
    logic [15:0] e_sel;
    logic        e_valid;
    logic [3:0]  e_owner;
  } vec_t;

  vec_t vecs [13];

  channel_arbiter #(.NREQ(16), .MAX_HOLD(TB_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .select  (select),
    .valid   (valid),
    .owner   (owner),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_out(input string name, input logic [15:0] es, input logic ev,
                         input logic [3:0] eo, input logic et);
    chk({name, ".select"},  32'(select),  32'(es));
    chk({name, ".valid"},   32'(valid),   32'(ev));
    chk({name, ".owner"},   32'(owner),   32'(eo));
    chk({name, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 0;
  endtask

  // Spec-level model: owner holds until done, request drop or hold limit; scan upward from ptr.
  task automatic model_update(input logic [15:0] r, input logic d);
    m_to = 0;
    if (m_valid != 0) begin
      if (d || !r[m_owner]) begin
        m_valid = 0;
      end else if (TO_EN && m_hold == TB_HOLD) begin
        m_valid = 0;
        m_to    = 1;
      end else begin
        m_hold++;
      end
      if (m_valid == 0) m_owner = 0;
    end else if (r != 16'h0) begin
      for (int i = 0; i < 16; i++) begin
        if (m_valid == 0 && r[(m_ptr + i) % 16]) begin
          m_owner = (m_ptr + i) % 16;
          m_valid = 1;
        end
      end
      m_ptr  = (m_owner + 1) % 16;
      m_hold = 1;
    end
  endtask

  task automatic step(input logic [15:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_update(r, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 16'h0;
    done  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] r;
    logic [15:0] es;
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    req     = 16'h0;
    done    = 1'b0;
    model_reset();

    vecs[0]  = '{16'h0001, 1'b0, 16'h0001, 1'b1, 4'd0};
    vecs[1]  = '{16'h0001, 1'b1, 16'h0000, 1'b0, 4'd0};
    vecs[2]  = '{16'h0001, 1'b0, 16'h0001, 1'b1, 4'd0};
    vecs[3]  = '{16'h0003, 1'b0, 16'h0001, 1'b1, 4'd0};
    vecs[4]  = '{16'h0002, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[5]  = '{16'h0002, 1'b0, 16'h0002, 1'b1, 4'd1};
    vecs[6]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0};
    vecs[7]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0};
    vecs[8]  = '{16'h8001, 1'b0, 16'h8000, 1'b1, 4'd15};
    vecs[9]  = '{16'h8001, 1'b1, 16'h0000, 1'b0, 4'd0};
    vecs[10] = '{16'h8001, 1'b0, 16'h0001, 1'b1, 4'd0};
    vecs[11] = '{16'h8001, 1'b1, 16'h0000, 1'b0, 4'd0};
    vecs[12] = '{16'h8001, 1'b0, 16'h8000, 1'b1, 4'd15};

    #3;
    chk_out("reset", 16'h0, 1'b0, 4'd0, 1'b0);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].d);
      chk_out($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_valid, vecs[i].e_owner, 1'b0);
    end

    // Full rotation with a zero-select bubble between owners
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      step(16'hFFFF, 1'b0);
      chk_out($sformatf("rot%0d", i), 16'(1 << (i % 16)), 1'b1, 4'(i % 16), 1'b0);
      step(16'hFFFF, 1'b1);
      chk_out($sformatf("rot%0d_bubble", i), 16'h0, 1'b0, 4'd0, 1'b0);
    end

    // Pointer at 15 wraps to 0 ahead of 1
    do_reset();
    step(16'h4000, 1'b0);
    chk_out("wrap_o14", 16'h4000, 1'b1, 4'd14, 1'b0);
    step(16'h4000, 1'b1);
    step(16'h0003, 1'b0);
    chk_out("wrap_o0", 16'h0001, 1'b1, 4'd0, 1'b0);

    // Request drop releases without done
    do_reset();
    step(16'h0020, 1'b0);
    chk_out("drop_o5", 16'h0020, 1'b1, 4'd5, 1'b0);
    step(16'h0000, 1'b0);
    chk_out("drop_rel", 16'h0, 1'b0, 4'd0, 1'b0);
    step(16'h0200, 1'b0);
    chk_out("drop_o9", 16'h0200, 1'b1, 4'd9, 1'b0);

    // Hold limit behaviour
    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TB_HOLD; i++) begin
      step(16'h0010, 1'b0);
      chk_out($sformatf("hold%0d", i), 16'h0010, 1'b1, 4'd4, 1'b0);
    end
    step(16'h0010, 1'b0);
    chk_out("to_pulse", 16'h0, 1'b0, 4'd0, 1'b1);
    step(16'h0010, 1'b0);
    chk_out("to_regrant", 16'h0010, 1'b1, 4'd4, 1'b0);
`else
    for (int i = 0; i < 10; i++) begin
      step(16'h0010, 1'b0);
      chk_out($sformatf("hold%0d", i), 16'h0010, 1'b1, 4'd4, 1'b0);
    end
`endif

    // Asynchronous reset mid-grant
    do_reset();
    step(16'h0001, 1'b0);
    step(16'h0001, 1'b0);
    chk_out("pre_rst", 16'h0001, 1'b1, 4'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 16'h0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(16'h0003, 1'b0);
    chk_out("rst_ptr0", 16'h0001, 1'b1, 4'd0, 1'b0);

    // Randomized traffic against the reference model
    do_reset();
    r = 16'h0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) r = 16'($urandom & $urandom & $urandom);
      step(r, ($urandom_range(5) == 0));
      es = (m_valid != 0) ? 16'(1 << m_owner) : 16'h0;
      chk_out($sformatf("rnd%0d", n), es, m_valid != 0, 4'(m_owner), m_to != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
